// File: rtl/dfii_wb_responder_if.sv
// rtl/dfii_wb_responder_if.sv - Wishbone classic bus bundle for the DFII register bank
interface dfii_wb_responder_if;
    logic [29:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;

    modport master (output adr, dat_w, sel, cyc, stb, we, input dat_r, ack);
    modport slave  (input adr, dat_w, sel, cyc, stb, we, output dat_r, ack);
endinterface

// File: rtl/dfii_wb_responder.sv
// rtl/dfii_wb_responder.sv - DFII software-injection register bank driving DFI phase 0
module dfii_wb_responder #(
    parameter logic [29:0] BASE_ADR = 30'h2400,
    parameter int          ADDR_W   = 14,
    parameter int          BA_W     = 3,
    parameter int          DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dfii_wb_responder_if.slave   wb,
    output logic                 dfii_sel,
    output logic                 dfi_cke,
    output logic                 dfi_odt,
    output logic                 dfi_reset_n,
    output logic                 dfi_cs_n,
    output logic                 dfi_ras_n,
    output logic                 dfi_cas_n,
    output logic                 dfi_we_n,
    output logic [ADDR_W-1:0]    dfi_address,
    output logic [BA_W-1:0]      dfi_bank,
    output logic                 dfi_wrdata_en,
    output logic                 dfi_rddata_en,
    output logic [DATA_W-1:0]    dfi_wrdata,
    input  logic [DATA_W-1:0]    dfi_rddata,
    input  logic                 dfi_rddata_valid
);
    localparam logic [2:0] OFF_CONTROL  = 3'd0;
    localparam logic [2:0] OFF_COMMAND  = 3'd1;
    localparam logic [2:0] OFF_ISSUE    = 3'd2;
    localparam logic [2:0] OFF_ADDRESS  = 3'd3;
    localparam logic [2:0] OFF_BADDRESS = 3'd4;
    localparam logic [2:0] OFF_WRDATA   = 3'd5;
    localparam logic [2:0] OFF_RDDATA   = 3'd6;

    typedef enum logic {IDLE, FIRE} state_t;

    logic [3:0]        control_q;
    logic [5:0]        command_q;
    logic [ADDR_W-1:0] address_q;
    logic [BA_W-1:0]   bank_q;
    logic [DATA_W-1:0] wrdata_q;
    logic [DATA_W-1:0] rddata_q;

    logic        pend_q;
    logic        ack_q;
    logic [31:0] dat_r_q;
    logic        req_hit;
    logic        do_access;
    logic        wr_en;
    logic        issue;
    logic [2:0]  off;
    logic [31:0] bmask;
    logic [31:0] rd_val;

    state_t state_q, state_d;
    logic   cs_n_d, ras_n_d, cas_n_d, we_n_d, wren_d, rden_d;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    assign off       = wb.adr[2:0];
    assign req_hit   = wb.cyc & wb.stb & (wb.adr[29:3] == BASE_ADR[29:3]);
    assign do_access = pend_q & req_hit;
    assign wr_en     = do_access & wb.we;
    assign issue     = wr_en & (off == OFF_ISSUE) & wb.sel[0] & wb.dat_w[0] & ~control_q[0];

    always_comb begin
        bmask = '0;
        for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{wb.sel[i]}};
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_CONTROL:  rd_val = 32'(control_q);
            OFF_COMMAND:  rd_val = 32'(command_q);
            OFF_ADDRESS:  rd_val = 32'(address_q);
            OFF_BADDRESS: rd_val = 32'(bank_q);
            OFF_WRDATA:   rd_val = 32'(wrdata_q);
            OFF_RDDATA:   rd_val = 32'(rddata_q);
            default:      rd_val = '0;
        endcase
    end

    // The edge that drops ack also samples the next request, so held strobes ack every other cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_r_q <= '0;
        end else if (ack_q) begin
            ack_q   <= 1'b0;
            dat_r_q <= '0;
            pend_q  <= req_hit;
        end else if (pend_q) begin
            pend_q  <= 1'b0;
            ack_q   <= req_hit;
            dat_r_q <= (req_hit && !wb.we) ? rd_val : '0;
        end else begin
            pend_q  <= req_hit;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.dat_r = dat_r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control_q <= 4'h1;
            command_q <= '0;
            address_q <= '0;
            bank_q    <= '0;
            wrdata_q  <= '0;
            rddata_q  <= '0;
        end else begin
            if (dfi_rddata_valid) rddata_q <= dfi_rddata;
            if (wr_en) begin
                case (off)
                    OFF_CONTROL:  control_q <= 4'(merge(32'(control_q), wb.dat_w, bmask));
                    OFF_COMMAND:  command_q <= 6'(merge(32'(command_q), wb.dat_w, bmask));
                    OFF_ADDRESS:  address_q <= ADDR_W'(merge(32'(address_q), wb.dat_w, bmask));
                    OFF_BADDRESS: bank_q    <= BA_W'(merge(32'(bank_q), wb.dat_w, bmask));
                    OFF_WRDATA:   wrdata_q  <= DATA_W'(merge(32'(wrdata_q), wb.dat_w, bmask));
                    default:      ;
                endcase
            end
        end
    end

    assign dfii_sel    = control_q[0];
    assign dfi_cke     = control_q[1];
    assign dfi_odt     = control_q[2];
    assign dfi_reset_n = control_q[3];
    assign dfi_address = address_q;
    assign dfi_bank    = bank_q;
    assign dfi_wrdata  = wrdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cs_n_d  = 1'b1;
        ras_n_d = 1'b1;
        cas_n_d = 1'b1;
        we_n_d  = 1'b1;
        wren_d  = 1'b0;
        rden_d  = 1'b0;
        case (state_q)
            IDLE: if (issue) state_d = FIRE;
            FIRE: begin
                state_d = IDLE;
                cs_n_d  = ~command_q[0];
                we_n_d  = ~command_q[1];
                cas_n_d = ~command_q[2];
                ras_n_d = ~command_q[3];
                wren_d  = command_q[4];
                rden_d  = command_q[5];
            end
            default: state_d = IDLE;
        endcase
    end

    // Command lines are re-registered so the pulse lands one cycle after FIRE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dfi_cs_n      <= 1'b1;
            dfi_ras_n     <= 1'b1;
            dfi_cas_n     <= 1'b1;
            dfi_we_n      <= 1'b1;
            dfi_wrdata_en <= 1'b0;
            dfi_rddata_en <= 1'b0;
        end else begin
            dfi_cs_n      <= cs_n_d;
            dfi_ras_n     <= ras_n_d;
            dfi_cas_n     <= cas_n_d;
            dfi_we_n      <= we_n_d;
            dfi_wrdata_en <= wren_d;
            dfi_rddata_en <= rden_d;
        end
    end
endmodule

// File: tb/tb_dfii_wb_responder.sv
// tb/tb_dfii_wb_responder.sv - self-checking bench for dfii_wb_responder
module tb_dfii_wb_responder;
    localparam logic [29:0] BASE = 30'h2400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dfii_sel, dfi_cke, dfi_odt, dfi_reset_n;
    logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [13:0] dfi_address;
    logic [2:0]  dfi_bank;
    logic        dfi_wrdata_en, dfi_rddata_en;
    logic [31:0] dfi_wrdata;
    logic [31:0] dfi_rddata = '0;
    logic        dfi_rddata_valid = 1'b0;

    dfii_wb_responder_if wb();

    dfii_wb_responder dut (
        .clk(clk), .rst_n(rst_n), .wb(wb),
        .dfii_sel(dfii_sel), .dfi_cke(dfi_cke), .dfi_odt(dfi_odt), .dfi_reset_n(dfi_reset_n),
        .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
        .dfi_address(dfi_address), .dfi_bank(dfi_bank),
        .dfi_wrdata_en(dfi_wrdata_en), .dfi_rddata_en(dfi_rddata_en),
        .dfi_wrdata(dfi_wrdata), .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    typedef struct {
        int          cyc;
        logic [22:0] lines;
    } pulse_t;
    pulse_t pq[$];

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk)
        if (rst_n && (!dfi_cs_n || !dfi_ras_n || !dfi_cas_n || !dfi_we_n || dfi_wrdata_en || dfi_rddata_en))
            pq.push_back('{cycle, {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
                                   dfi_wrdata_en, dfi_rddata_en, dfi_address, dfi_bank}});

    // Reference register image
    logic [3:0]  m_ctrl;
    logic [5:0]  m_cmd;
    logic [13:0] m_addr;
    logic [2:0]  m_bank;
    logic [31:0] m_wr;
    logic [31:0] m_rd;

    task automatic model_reset();
        m_ctrl = 4'h1; m_cmd = '0; m_addr = '0; m_bank = '0; m_wr = '0; m_rd = '0;
    endtask

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0: return {28'h0, m_ctrl};
            1: return {26'h0, m_cmd};
            3: return {18'h0, m_addr};
            4: return {29'h0, m_bank};
            5: return m_wr;
            6: return m_rd;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input int off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] img;
        img = model_read(off);
        for (int b = 0; b < 4; b++)
            if (sel[b]) img[8*b +: 8] = d[8*b +: 8];
        case (off)
            0: m_ctrl = img[3:0];
            1: m_cmd  = img[5:0];
            3: m_addr = img[13:0];
            4: m_bank = img[2:0];
            5: m_wr   = img;
            default: ;
        endcase
    endtask

    function automatic logic [22:0] expected_lines();
        return {~m_cmd[0], ~m_cmd[3], ~m_cmd[2], ~m_cmd[1], m_cmd[4], m_cmd[5], m_addr, m_bank};
    endfunction

    task automatic wb_access(input logic [29:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdat,
                             output int lat, output int ack_cyc);
        lat = -1; rdat = '0; ack_cyc = -1;
        @(negedge clk);
        wb.adr = adr; wb.we = we; wb.dat_w = dat; wb.sel = sel;
        wb.cyc = 1'b1; wb.stb = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (wb.ack === 1'b1) begin
                lat = k; rdat = wb.dat_r; ack_cyc = cycle;
                break;
            end
        end
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        if (lat > 0 && we && adr[29:3] == BASE[29:3]) model_write(int'(adr[2:0]), dat, sel);
    endtask

    task automatic test_reset();
        wb.adr = '0; wb.dat_w = '0; wb.sel = '0; wb.cyc = 0; wb.stb = 0; wb.we = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({dfii_sel, dfi_reset_n, dfi_cke, dfi_odt} !== 4'b1000) begin
            failures++; $display("FAIL reset_ctrl_held got=%b exp=1000", {dfii_sel, dfi_reset_n, dfi_cke, dfi_odt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_wrdata_en, dfi_rddata_en} !== 6'b111100) begin
            failures++; $display("FAIL reset_cmd_lines got=%b exp=111100",
                                 {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_wrdata_en, dfi_rddata_en});
        end
        checks++;
        if ({wb.ack, wb.dat_r, dfi_address, dfi_bank, dfi_wrdata} !== '0) begin
            failures++; $display("FAIL reset_bus_regs ack=%b dat_r=%h addr=%h bank=%h wr=%h exp all zero",
                                 wb.ack, wb.dat_r, dfi_address, dfi_bank, dfi_wrdata);
        end
        checks++;
        if ({dfii_sel, dfi_reset_n, dfi_cke, dfi_odt} !== 4'b1000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=1000", {dfii_sel, dfi_reset_n, dfi_cke, dfi_odt});
        end
    endtask

    task automatic test_control();
        logic [31:0] r; int lat, ac;
        wb_access(BASE + 0, 1'b1, 32'h0C, 4'hF, r, lat, ac);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL ctrl_latency_1 got=%0d exp=2", lat); end
        @(negedge clk);
        checks++;
        if (wb.ack !== 1'b0) begin failures++; $display("FAIL ack_single_cycle got=%b exp=0", wb.ack); end
        checks++;
        if ({dfi_reset_n, dfi_odt, dfi_cke, dfii_sel} !== 4'b1100) begin
            failures++; $display("FAIL ctrl_0c got=%b exp=1100", {dfi_reset_n, dfi_odt, dfi_cke, dfii_sel});
        end
        wb_access(BASE + 0, 1'b1, 32'h0E, 4'hF, r, lat, ac);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL ctrl_latency_2 got=%0d exp=2", lat); end
        checks++;
        if ({dfi_reset_n, dfi_odt, dfi_cke, dfii_sel} !== 4'b1110) begin
            failures++; $display("FAIL ctrl_0e got=%b exp=1110", {dfi_reset_n, dfi_odt, dfi_cke, dfii_sel});
        end
    endtask

    task automatic test_commands();
        logic [31:0] r; int lat, ac;
        logic [13:0] ta[5]; logic [2:0] tb_[5]; logic [5:0] tc[5];
        ta[0] = 14'h200; tb_[0] = 3'd2; tc[0] = 6'h0F;
        ta[1] = 14'h400; tb_[1] = 3'd0; tc[1] = 6'h03;
        for (int i = 2; i < 5; i++) begin
            ta[i] = 14'($urandom); tb_[i] = 3'($urandom); tc[i] = 6'($urandom_range(1, 63));
        end
        for (int i = 0; i < 5; i++) begin
            wb_access(BASE + 3, 1'b1, {18'h0, ta[i]}, 4'hF, r, lat, ac);
            wb_access(BASE + 4, 1'b1, {29'h0, tb_[i]}, 4'hF, r, lat, ac);
            wb_access(BASE + 1, 1'b1, {26'h0, tc[i]}, 4'hF, r, lat, ac);
            pq.delete();
            wb_access(BASE + 2, 1'b1, 32'h1, 4'hF, r, lat, ac);
            repeat (4) @(negedge clk);
            checks++;
            if (pq.size() !== 1) begin
                failures++; $display("FAIL cmd%0d_pulse_count got=%0d exp=1", i, pq.size());
            end else begin
                checks++;
                if (pq[0].cyc !== ac + 1 || pq[0].lines !== expected_lines()) begin
                    failures++; $display("FAIL cmd%0d_pulse got=cyc%0d/%h exp=cyc%0d/%h",
                                         i, pq[0].cyc, pq[0].lines, ac + 1, expected_lines());
                end
            end
        end
    endtask

    task automatic test_ownership();
        logic [31:0] r; int lat, ac;
        wb_access(BASE + 0, 1'b1, 32'h01, 4'hF, r, lat, ac);
        pq.delete();
        wb_access(BASE + 2, 1'b1, 32'h01, 4'hF, r, lat, ac);
        repeat (4) @(negedge clk);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL own_issue_ack got=%0d exp=2", lat); end
        checks++;
        if (pq.size() !== 0) begin failures++; $display("FAIL own_no_pulse got=%0d exp=0", pq.size()); end
        checks++;
        if (dfii_sel !== 1'b1) begin failures++; $display("FAIL own_sel got=%b exp=1", dfii_sel); end
    endtask

    task automatic test_decode();
        logic [31:0] r; int lat, ac;
        wb_access(BASE + 1, 1'b1, 32'h0F, 4'hF, r, lat, ac);
        wb_access(BASE + 1, 1'b0, 32'h0, 4'hF, r, lat, ac);
        checks++;
        if (r !== 32'h0000000F) begin failures++; $display("FAIL read_command got=%h exp=0000000f", r); end
        @(negedge clk);
        dfi_rddata = 32'hFACECA8C; dfi_rddata_valid = 1'b1;
        @(negedge clk);
        dfi_rddata_valid = 1'b0; m_rd = 32'hFACECA8C;
        wb_access(BASE + 6, 1'b0, 32'h0, 4'hF, r, lat, ac);
        checks++;
        if (r !== 32'hFACECA8C) begin failures++; $display("FAIL read_rddata got=%h exp=facecа8c", r); end
        // rddata_valid arriving on the ack edge: old value read, new value stored
        @(negedge clk);
        wb.adr = BASE + 6; wb.we = 1'b0; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
        @(posedge clk); @(negedge clk);
        dfi_rddata = 32'h13572468; dfi_rddata_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        dfi_rddata_valid = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0;
        checks++;
        if (wb.ack !== 1'b1 || wb.dat_r !== 32'hFACECA8C) begin
            failures++; $display("FAIL rddata_collide ack=%b got=%h exp=facecа8c", wb.ack, wb.dat_r);
        end
        m_rd = 32'h13572468;
        wb_access(BASE + 6, 1'b0, 32'h0, 4'hF, r, lat, ac);
        checks++;
        if (r !== 32'h13572468) begin failures++; $display("FAIL rddata_after_collide got=%h exp=13572468", r); end
        wb_access(BASE + 3, 1'b1, 32'h1234, 4'hF, r, lat, ac);
        wb_access(BASE + 3, 1'b1, 32'hFFFFFFAB, 4'b0001, r, lat, ac);
        wb_access(BASE + 3, 1'b0, 32'h0, 4'hF, r, lat, ac);
        checks++;
        if (r !== 32'h000012AB || dfi_address !== 14'h12AB) begin
            failures++; $display("FAIL byte_write got=%h/%h exp=000012ab/12ab", r, dfi_address);
        end
        wb_access(BASE + 2, 1'b0, 32'h0, 4'hF, r, lat, ac);
        checks++;
        if (r !== 32'h0 || lat !== 2) begin failures++; $display("FAIL read_issue got=%h lat=%0d exp=0 lat=2", r, lat); end
        wb_access(BASE + 7, 1'b1, 32'hFFFFFFFF, 4'hF, r, lat, ac);
        wb_access(BASE + 7, 1'b0, 32'h0, 4'hF, r, lat, ac);
        checks++;
        if (r !== 32'h0 || lat !== 2) begin failures++; $display("FAIL read_unmapped got=%h lat=%0d exp=0 lat=2", r, lat); end
        wb_access(BASE + 8, 1'b1, 32'hFFFFFFFF, 4'hF, r, lat, ac);
        checks++;
        if (lat !== -1) begin failures++; $display("FAIL out_of_window got=%0d exp=no ack", lat); end
    endtask

    task automatic test_back_to_back();
        logic exp_ack[4];
        exp_ack[0] = 0; exp_ack[1] = 1; exp_ack[2] = 0; exp_ack[3] = 1;
        @(negedge clk);
        wb.adr = BASE + 1; wb.we = 1'b0; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (wb.ack !== exp_ack[k]) begin
                failures++; $display("FAIL b2b_ack%0d got=%b exp=%b", k, wb.ack, exp_ack[k]);
            end
            if (k == 1) begin
                checks++;
                if (wb.dat_r !== model_read(1)) begin
                    failures++; $display("FAIL b2b_data0 got=%h exp=%h", wb.dat_r, model_read(1));
                end
                wb.adr = BASE + 3;
            end
        end
        checks++;
        if (wb.dat_r !== model_read(3)) begin
            failures++; $display("FAIL b2b_data1 got=%h exp=%h", wb.dat_r, model_read(3));
        end
        wb.cyc = 1'b0; wb.stb = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] r, d, exp_r; logic [3:0] sel; logic we, inwin, exp_fire;
        logic [22:0] exp_lines;
        int off, lat, ac, exp_n;
        logic [29:0] adr;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                dfi_rddata = $urandom; dfi_rddata_valid = 1'b1;
                @(negedge clk);
                dfi_rddata_valid = 1'b0; m_rd = dfi_rddata;
            end
            off = $urandom_range(0, 7);
            inwin = ($urandom_range(0, 7) != 0);
            adr = inwin ? BASE + 30'(off) : BASE + 30'd8 + 30'($urandom_range(0, 4000));
            we = $urandom_range(0, 1);
            d = $urandom; sel = 4'($urandom);
            if (off == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            exp_r = model_read(off);
            exp_fire = inwin && we && off == 2 && sel[0] && d[0] && !m_ctrl[0] && m_cmd != 0;
            exp_lines = expected_lines();
            exp_n = exp_fire ? 1 : 0;
            pq.delete();
            wb_access(adr, we, d, sel, r, lat, ac);
            repeat (3) @(negedge clk);
            checks++;
            if (lat !== (inwin ? 2 : -1)) begin
                failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, lat, inwin ? 2 : -1);
            end
            if (inwin && !we) begin
                checks++;
                if (r !== exp_r) begin failures++; $display("FAIL rnd%0d_read off=%0d got=%h exp=%h", it, off, r, exp_r); end
            end
            checks++;
            if ({dfii_sel, dfi_cke, dfi_odt, dfi_reset_n} !== {m_ctrl[0], m_ctrl[1], m_ctrl[2], m_ctrl[3]} ||
                dfi_address !== m_addr || dfi_bank !== m_bank || dfi_wrdata !== m_wr) begin
                failures++; $display("FAIL rnd%0d_outputs got=%b/%h/%h/%h exp=%b/%h/%h/%h", it,
                    {dfii_sel, dfi_cke, dfi_odt, dfi_reset_n}, dfi_address, dfi_bank, dfi_wrdata,
                    {m_ctrl[0], m_ctrl[1], m_ctrl[2], m_ctrl[3]}, m_addr, m_bank, m_wr);
            end
            checks++;
            if (pq.size() !== exp_n) begin
                failures++; $display("FAIL rnd%0d_pulse_count got=%0d exp=%0d", it, pq.size(), exp_n);
            end else if (exp_n == 1) begin
                checks++;
                if (pq[0].cyc !== ac + 1 || pq[0].lines !== exp_lines) begin
                    failures++; $display("FAIL rnd%0d_pulse got=cyc%0d/%h exp=cyc%0d/%h",
                                         it, pq[0].cyc, pq[0].lines, ac + 1, exp_lines);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] r; int lat, ac;
        wb_access(BASE + 0, 1'b1, 32'h0E, 4'hF, r, lat, ac);
        wb_access(BASE + 1, 1'b1, 32'h0F, 4'hF, r, lat, ac);
        wb_access(BASE + 2, 1'b1, 32'h01, 4'hF, r, lat, ac);
        @(negedge clk);
        checks++;
        if (dfi_cs_n !== 1'b0) begin failures++; $display("FAIL areset_pulse_present got=%b exp=0", dfi_cs_n); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfii_sel} !== 5'b11111) begin
            failures++; $display("FAIL areset_idle got=%b exp=11111", {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfii_sel});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wb_access(BASE + 0, 1'b0, 32'h0, 4'hF, r, lat, ac);
        checks++;
        if (r !== 32'h1) begin failures++; $display("FAIL areset_control got=%h exp=00000001", r); end
    endtask

    initial begin
        test_reset();
        test_control();
        test_commands();
        test_ownership();
        test_decode();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end
endmodule
